valid_rate_monitor: RTL and testbench

//  Sink-side checker for the periodic single-cycle sample strobe driven by the valid generator.

---
 rtl/valid_rate_monitor.sv | 119 +++++++++++
 tb/tb_valid_rate_monitor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/valid_rate_monitor.sv
// Sink-side checker for a periodic single-cycle strobe: measures period, declares lock, flags early/missing pulses.
// Optional min/max period statistics (plus stats_clr) are enabled by defining VALID_RATE_MONITOR_STATS_EN.
module valid_rate_monitor #(
  parameter int CLK_FREQ    = 10_000_000,
  parameter int TARGET_FREQ = 48_000,
  parameter int TOLERANCE   = 2,
  parameter int LOCK_COUNT  = 4,
  localparam int NOMINAL    = CLK_FREQ / TARGET_FREQ,
  localparam int PMAX       = NOMINAL + TOLERANCE,
  localparam int PMIN       = NOMINAL - TOLERANCE,
  localparam int W          = $clog2(PMAX + 2)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         early_err,
  output logic         late_err,
`ifdef VALID_RATE_MONITOR_STATS_EN
  input  logic         stats_clr,
  output logic [W-1:0] period_min,
  output logic [W-1:0] period_max,
`endif
  output logic [15:0]  err_count
);

  localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [W-1:0]  PMAX_W = W'(PMAX);
  localparam logic [W-1:0]  PMIN_W = W'(PMIN);
  localparam logic [GW-1:0] LOCK_G = GW'(LOCK_COUNT);

  if (TOLERANCE >= NOMINAL || LOCK_COUNT < 1) begin : g_param_check
    $error("valid_rate_monitor: TOLERANCE must be < NOMINAL and LOCK_COUNT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t        state;
  logic [W-1:0]  cnt;
  logic [GW-1:0] good;
  logic          active;
  logic          early_hit;
  logic          late_hit;

  // A gap can only time out while valid_in is low, so early and late never coincide.
  always_comb begin
    active    = (state != IDLE);
    early_hit = active && valid_in && (cnt < PMIN_W);
    late_hit  = active && !valid_in && (cnt == PMAX_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      good         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      early_err    <= 1'b0;
      late_err     <= 1'b0;
      err_count    <= '0;
    end else begin
      period_valid <= 1'b0;
      early_err    <= early_hit;
      late_err     <= late_hit;
      if ((early_hit || late_hit) && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;

      if (!active) begin
        cnt  <= valid_in ? W'(1) : '0;
        good <= '0;
        if (valid_in)
          state <= ACQUIRE;
      end else if (valid_in) begin
        cnt          <= W'(1);
        period       <= cnt;
        period_valid <= 1'b1;
        if (early_hit) begin
          good   <= '0;
          state  <= ACQUIRE;
          locked <= 1'b0;
        end else begin
          if (good != LOCK_G)
            good <= good + GW'(1);
          if (good >= LOCK_G - GW'(1)) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
      end else if (late_hit) begin
        cnt    <= '0;
        good   <= '0;
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

`ifdef VALID_RATE_MONITOR_STATS_EN
  // Clear wins over a same-cycle measurement.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      period_min <= '1;
      period_max <= '0;
    end else if (active && valid_in) begin
      if (cnt < period_min)
        period_min <= cnt;
      if (cnt > period_max)
        period_max <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_valid_rate_monitor.sv
// Directed bench for valid_rate_monitor at default parameters (NOMINAL 208, window 206..210, lock after 4).
module tb_valid_rate_monitor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [W-1:0] period;
  logic         period_valid;
  logic         locked;
  logic         early_err;
  logic         late_err;
  logic [15:0]  err_count;
`ifdef VALID_RATE_MONITOR_STATS_EN
  logic         stats_clr;
  logic [W-1:0] period_min;
  logic [W-1:0] period_max;
`endif

  int checks = 0;
  int errors = 0;

  valid_rate_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .early_err    (early_err),
    .late_err     (late_err),
`ifdef VALID_RATE_MONITOR_STATS_EN
    .stats_clr    (stats_clr),
    .period_min   (period_min),
    .period_max   (period_max),
`endif
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // Outputs are read 1 time unit after the edge that produced them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  // Strobe p cycles after the previous one.
  task automatic gap(input int p);
    idle(p - 1);
    pulse();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b0;
`ifdef VALID_RATE_MONITOR_STATS_EN
    stats_clr = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    checks++; if (period !== 8'd0) begin errors++; $display("FAIL reset_period got %0d want 0", period); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_pv got %b want 0", period_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (early_err !== 1'b0 || late_err !== 1'b0) begin errors++; $display("FAIL reset_errs got %b%b want 00", early_err, late_err); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", err_count); end
  endtask

  task automatic test_lock();
    pulse();
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL lock_first_pv got %b want 0", period_valid); end
    for (int k = 1; k <= 4; k++) begin
      gap(208);
      checks++; if (period_valid !== 1'b1 || period !== 8'd208) begin errors++; $display("FAIL lock_period%0d got pv=%b p=%0d want pv=1 p=208", k, period_valid, period); end
      checks++; if (locked !== (k == 4)) begin errors++; $display("FAIL lock_state%0d got %b want %b", k, locked, k == 4); end
    end
  endtask

  task automatic test_early();
    gap(150);
    checks++; if (period !== 8'd150 || early_err !== 1'b1) begin errors++; $display("FAIL early_pulse got p=%0d e=%b want p=150 e=1", period, early_err); end
    checks++; if (locked !== 1'b0 || err_count !== 16'd1) begin errors++; $display("FAIL early_unlock got lk=%b ec=%0d want lk=0 ec=1", locked, err_count); end
    idle(1);
    checks++; if (early_err !== 1'b0) begin errors++; $display("FAIL early_single got %b want 0", early_err); end
    gap(207);
    gap(208);
    gap(208);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", locked); end
    gap(208);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", locked); end
  endtask

  task automatic test_timeout();
    bit extra;
    idle(209);
    checks++; if (late_err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL late_before got le=%b lk=%b want le=0 lk=1", late_err, locked); end
    idle(1);
    checks++; if (late_err !== 1'b1 || locked !== 1'b0 || err_count !== 16'd2) begin errors++; $display("FAIL late_pulse got le=%b lk=%b ec=%0d want 1 0 2", late_err, locked, err_count); end
    extra = 1'b0;
    for (int i = 0; i < 300; i++) begin
      idle(1);
      if (late_err) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0 || err_count !== 16'd2) begin errors++; $display("FAIL late_once got extra=%b ec=%0d want 0 2", extra, err_count); end
    pulse();
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL late_restart_pv got %b want 0", period_valid); end
  endtask

  task automatic test_alternate();
    gap(206);
    gap(210);
    checks++; if (period !== 8'd210 || early_err !== 1'b0 || late_err !== 1'b0) begin errors++; $display("FAIL alt_pmax got p=%0d e=%b l=%b want 210 0 0", period, early_err, late_err); end
    gap(206);
    gap(210);
    checks++; if (locked !== 1'b1 || err_count !== 16'd2) begin errors++; $display("FAIL alt_lock got lk=%b ec=%0d want 1 2", locked, err_count); end
    gap(205);
    checks++; if (early_err !== 1'b1 || period !== 8'd205 || err_count !== 16'd3) begin errors++; $display("FAIL alt_205 got e=%b p=%0d ec=%0d want 1 205 3", early_err, period, err_count); end
    idle(210);
    checks++; if (late_err !== 1'b1 || err_count !== 16'd4) begin errors++; $display("FAIL alt_211 got le=%b ec=%0d want 1 4", late_err, err_count); end
    pulse();
    checks++; if (period_valid !== 1'b0 || early_err !== 1'b0) begin errors++; $display("FAIL alt_211_strobe got pv=%b e=%b want 0 0", period_valid, early_err); end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 4; k++) gap(208);
    checks++; if (locked !== 1'b1 || err_count !== 16'd4) begin errors++; $display("FAIL prerst got lk=%b ec=%0d want 1 4", locked, err_count); end
    idle(207);
    rst = 1'b1;
    valid_in = 1'b1;
    tick();
    rst = 1'b0;
    valid_in = 1'b0;
    checks++; if (locked !== 1'b0 || period !== 8'd0 || period_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got lk=%b p=%0d pv=%b want 0 0 0", locked, period, period_valid); end
    checks++; if (err_count !== 16'd0 || early_err !== 1'b0 || late_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err got ec=%0d e=%b l=%b want 0 0 0", err_count, early_err, late_err); end
    idle(5);
    pulse();
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_pv got %b want 0", period_valid); end
  endtask

`ifdef VALID_RATE_MONITOR_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (period_min !== 8'hFF || period_max !== 8'h00) begin errors++; $display("FAIL stats_reset got min=%0d max=%0d want 255 0", period_min, period_max); end
    pulse();
    gap(207);
    gap(209);
    gap(208);
    checks++; if (period_min !== 8'd207 || period_max !== 8'd209) begin errors++; $display("FAIL stats_minmax got min=%0d max=%0d want 207 209", period_min, period_max); end
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    checks++; if (period_min !== 8'hFF || period_max !== 8'h00) begin errors++; $display("FAIL stats_clr got min=%0d max=%0d want 255 0", period_min, period_max); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_early();
    test_timeout();
    test_alternate();
    test_mid_reset();
`ifdef VALID_RATE_MONITOR_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
